bit_stream_unpacker: RTL and testbench
======================================

# bit_stream_unpacker

Parametrised bit-granular stream unpacker that accepts fixed-width words from an upstream FIFO and presents a sliding window of the oldest buffered bits to a variable-length symbol decoder. The decoder consumes 0..WIDTH_OUT bits per cycle. Compared with the first-generation unpacker, this block adds:
- a valid/ready input handshake whose ready depends only on registered state;
- a full-buffer-capable occupancy count and a valid-bit count on the output window;
- pop clamping, flush, and optional sticky error reporting.

## Interface
- WIDTH_IN, 32, input word width in bits
- WIDTH_OUT, 16, output window width; maximum bits popped per cycle
- BUFFER_WIDTH, 64, bit buffer capacity; must be >= WIDTH_IN + WIDTH_OUT
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (decided)
- d_valid  in  1  input word valid
- d_ready  out  1  buffer can accept a full WIDTH_IN word
- d  in  WIDTH_IN  input word; bit 0 is the oldest bit in the stream
- pop  in  POP_W = clog2(WIDTH_OUT+1)  number of bits consumed this cycle
- flush  in  1  discard all buffered bits
- q  out  WIDTH_OUT  oldest buffered bits, oldest at bit 0; bits at or above q_count read 0
- q_count  out  POP_W  valid bits in q = min(size, WIDTH_OUT)
- size  out  SIZE_W = clog2(BUFFER_WIDTH+1)  buffered bit count, range 0..BUFFER_WIDTH
- err_clr  in  1  clears err (macro only)
- err  out  1  sticky pop-underflow/overrange flag (macro only)

## Operation
- Registered state: buffer[BUFFER_WIDTH], size. Invariant: buffer bits at index >= size are 0.
- pop_eff = min(pop, WIDTH_OUT, size). A pop request above size or above WIDTH_OUT is illegal and is clamped to pop_eff.
- Push is accepted when d_valid && d_ready.
- d_ready = (BUFFER_WIDTH - size) >= WIDTH_IN. It is a function of registered size only and has no combinational path from pop.
- Next state without flush:
  - buffer' = (buffer >> pop_eff) | (push ? d << (size - pop_eff) : 0)
  - size' = size - pop_eff + (push ? WIDTH_IN : 0)
- Flush has priority over pop:
  - buffer' = push ? d : 0
  - size' = push ? WIDTH_IN : 0
- Shift amounts are computed at SIZE_W+1 bits, so no wrap-around occurs.
- Outputs are derived from registered state:
  - q = buffer[WIDTH_OUT-1:0]
  - q_count = min(size, WIDTH_OUT)

## Timing
- Reset values: buffer 0, size 0, q 0, q_count 0, d_ready 1, err 0.
- Push-to-q latency is 1 cycle. Pop takes effect on q, size and d_ready in the next cycle.
- Reset asserted in the same cycle as push, pop or flush: reset wins; the pushed word is dropped.
- Boundary cases:
  - size = BUFFER_WIDTH: d_ready = 0 and size is representable.
  - size = 0 with pop > 0: no change, err set (macro only).
- Simultaneous pop and push: the appended word lands at offset size - pop_eff.

## Configuration
- BIT_STREAM_UNPACKER_ERR_EN defined:
  - err register present.
  - err is set the cycle after any pop > size or pop > WIDTH_OUT.
  - err_clr clears it; if err_clr coincides with a new violation, set wins.
- Undefined:
  - err tied to 0; err_clr ignored.
  - The clamp behaviour is unchanged.

## Structure
- Shared package bit_unpack_pkg holds:
  - the clog2 function;
  - derivation helpers for SIZE_W and POP_W;
  - the parameter legality check (BUFFER_WIDTH >= WIDTH_IN + WIDTH_OUT).
- One sub-module, bit_unpack_align_shift: combinational left-shift of d by the insertion offset into a BUFFER_WIDTH field.
- The top level holds the registers, the clamp logic and d_ready.

## Test plan
The bench uses WIDTH_IN=8, WIDTH_OUT=8, BUFFER_WIDTH=16, with the macro defined unless stated otherwise.
- Reset then push 0xA5: outputs show size 0, q_count 0, d_ready 1; next cycle shows size 8, q 0xA5, q_count 8.
- Push 0xA5 then 0x3C: size 16, q 0xA5, d_ready 0. Pop 4: size 12, q 0xCA, d_ready 0. Pop 4: size 8, q 0x3C, d_ready 1.
- Size 8 holding 0xA5, pop 4 with push 0x3C in the same cycle: size 12, q 0xCA.
- Size 5, pop 7: size 0, q 0, err 1. Then err_clr: err 0. With the macro undefined: size 0 and err stays 0.
- Size 12, flush with push 0x77 in the same cycle: size 8, q 0x77. Flush alone: size 0, q_count 0.
- Size 12 with push and pop asserted while rst=1: size 0, q 0, d_ready 1, err 0 in the next cycle.

Source files
------------

// File: rtl/bit_unpack_pkg.sv
// bit_unpack_pkg: shared helpers for the bit stream unpacker.
// Holds the width derivations and the parameter legality check used at
// elaboration by bit_stream_unpacker.
package bit_unpack_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(0) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width of a counter spanning 0..bw inclusive.
  function automatic int size_w(input int bw);
    return clog2(bw + 1);
  endfunction

  // Width of a pop request spanning 0..wo inclusive.
  function automatic int pop_w(input int wo);
    return clog2(wo + 1);
  endfunction

  // The buffer must hold a full window plus one incoming word, otherwise
  // d_ready could stall forever while the decoder still needs bits.
  function automatic bit params_ok(input int wi, input int wo, input int bw);
    return (wi > 0) && (wo > 0) && (bw >= wi + wo);
  endfunction

endpackage

// File: rtl/bit_unpack_align_shift.sv
// bit_unpack_align_shift: places an input word at a bit offset inside a
// BUFFER_WIDTH field. Built as a log-depth barrel shifter, one stage per
// offset bit. Offsets that push bits past the top simply drop them; the
// caller only uses the result when the word fits.
module bit_unpack_align_shift #(
  parameter int WIDTH_IN     = 32,
  parameter int BUFFER_WIDTH = 64,
  parameter int SH_W         = 8
) (
  input  logic [WIDTH_IN-1:0]     d_i,
  input  logic [SH_W-1:0]         off_i,
  output logic [BUFFER_WIDTH-1:0] ins_o
);

  logic [SH_W:0][BUFFER_WIDTH-1:0] stg;

  assign stg[0] = BUFFER_WIDTH'(d_i);

  for (genvar s = 0; s < SH_W; s++) begin : g_stage
    assign stg[s+1] = off_i[s] ? (stg[s] << (2 ** s)) : stg[s];
  end

  assign ins_o = stg[SH_W];

endmodule

// File: rtl/bit_stream_unpacker.sv
// bit_stream_unpacker: bit-granular FIFO-to-decoder unpacker.
// Words enter on a valid/ready handshake and are appended behind the
// buffered bits; the decoder sees the oldest WIDTH_OUT bits and consumes
// 0..WIDTH_OUT of them per cycle. Over-sized pops are clamped.
// Optional feature macro: BIT_STREAM_UNPACKER_ERR_EN enables the sticky
// err flag for illegal pops; without it err reads 0 and err_clr_i is ignored.
module bit_stream_unpacker
  import bit_unpack_pkg::*;
#(
  parameter  int WIDTH_IN     = 32,
  parameter  int WIDTH_OUT    = 16,
  parameter  int BUFFER_WIDTH = 64,
  localparam int SIZE_W       = size_w(BUFFER_WIDTH),
  localparam int POP_W        = pop_w(WIDTH_OUT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 d_valid_i,
  output logic                 d_ready_o,
  input  logic [WIDTH_IN-1:0]  d_i,
  input  logic [POP_W-1:0]     pop_i,
  input  logic                 flush_i,
  output logic [WIDTH_OUT-1:0] q_o,
  output logic [POP_W-1:0]     q_count_o,
  output logic [SIZE_W-1:0]    size_o,
  input  logic                 err_clr_i,
  output logic                 err_o
);

  if (!params_ok(WIDTH_IN, WIDTH_OUT, BUFFER_WIDTH)) begin : g_bad_params
    $error("bit_stream_unpacker: BUFFER_WIDTH must be >= WIDTH_IN + WIDTH_OUT");
  end

  // One spare bit so size - pop and the shift amounts never wrap.
  localparam int SH_W = SIZE_W + 1;
  typedef logic [SH_W-1:0] sh_t;

  localparam sh_t WO_X = sh_t'(WIDTH_OUT);
  localparam sh_t WI_X = sh_t'(WIDTH_IN);
  localparam sh_t BW_X = sh_t'(BUFFER_WIDTH);

  logic [BUFFER_WIDTH-1:0] buf_q, buf_d, ins;
  logic [SIZE_W-1:0]       size_q, size_d;
  sh_t                     size_x, pop_x, pop_lim, pop_eff, ins_off;
  logic                    ready, push, pop_ovr;

  // Clamp the pop request to what is both legal and actually buffered.
  always_comb begin
    size_x  = sh_t'(size_q);
    pop_x   = sh_t'(pop_i);
    pop_lim = (size_x < WO_X) ? size_x : WO_X;
    pop_eff = (pop_x > pop_lim) ? pop_lim : pop_x;
    pop_ovr = (pop_x > pop_lim);
  end

  // Ready looks only at registered size, so there is no path from pop_i.
  assign ready     = (BW_X - size_x) >= WI_X;
  assign d_ready_o = ready;
  assign push      = d_valid_i & ready;

  // After a flush the new word becomes the oldest data, so it lands at 0.
  assign ins_off = flush_i ? '0 : (size_x - pop_eff);

  bit_unpack_align_shift #(
    .WIDTH_IN     (WIDTH_IN),
    .BUFFER_WIDTH (BUFFER_WIDTH),
    .SH_W         (SH_W)
  ) u_align (
    .d_i   (d_i),
    .off_i (ins_off),
    .ins_o (ins)
  );

  // Next buffer/size: drop consumed bits (or everything on flush), then append.
  always_comb begin
    buf_d  = flush_i ? '0 : (buf_q >> pop_eff);
    size_d = flush_i ? '0 : (size_q - SIZE_W'(pop_eff));
    if (push) begin
      buf_d  = buf_d | ins;
      size_d = size_d + SIZE_W'(WIDTH_IN);
    end
  end

  // Bit buffer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q  <= '0;
      size_q <= '0;
    end else begin
      buf_q  <= buf_d;
      size_q <= size_d;
    end
  end

  // Bits above size are held at 0, so the window needs no masking.
  assign q_o       = buf_q[WIDTH_OUT-1:0];
  assign q_count_o = POP_W'(pop_lim);
  assign size_o    = size_q;

`ifdef BIT_STREAM_UNPACKER_ERR_EN
  logic err_q;

  // Sticky illegal-pop flag; a fresh violation beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (pop_ovr)   err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

  assign err_o = err_q;
`else
  logic unused_err_in;
  assign unused_err_in = err_clr_i ^ pop_ovr;
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_bit_stream_unpacker.sv
// tb_bit_stream_unpacker: scoreboard bench. The driver applies one cycle of
// stimulus, advances a bit-queue reference model and queues the expected
// output state; the monitor compares the DUT state on every falling edge.
module tb_bit_stream_unpacker;

  localparam int WI = 8;
  localparam int WO = 8;
  localparam int BW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic [7:0] d = '0;
  logic [3:0] pop = '0;
  logic       flush = 1'b0;
  logic [7:0] q;
  logic [3:0] q_count;
  logic [4:0] size;
  logic       err_clr = 1'b0;
  logic       err;

  always #5 clk = ~clk;

  bit_stream_unpacker #(
    .WIDTH_IN     (WI),
    .WIDTH_OUT    (WO),
    .BUFFER_WIDTH (BW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .d_valid_i (d_valid),
    .d_ready_o (d_ready),
    .d_i       (d),
    .pop_i     (pop),
    .flush_i   (flush),
    .q_o       (q),
    .q_count_o (q_count),
    .size_o    (size),
    .err_clr_i (err_clr),
    .err_o     (err)
  );

  typedef struct {
    int unsigned q;
    int unsigned qc;
    int unsigned sz;
    int unsigned rdy;
    int unsigned err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the stream as a plain queue of bits, oldest first.
  bit   bq[$];
  bit   m_err = 1'b0;

`ifdef BIT_STREAM_UNPACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   n;
    n     = bq.size();
    e.sz  = n;
    e.qc  = (n < WO) ? n : WO;
    e.q   = 0;
    for (int i = 0; i < e.qc; i++) if (bq[i]) e.q |= (1 << i);
    e.rdy = ((BW - n) >= WI) ? 1 : 0;
    e.err = ERR_EN ? m_err : 0;
    return e;
  endfunction

  task automatic step(input bit r, input bit dv, input bit [7:0] dd,
                      input int p, input bit fl, input bit clr);
    int  n, pe;
    bit  do_push, viol;
    exp_t e;
    @(negedge clk);
    rst = r; d_valid = dv; d = dd; pop = 4'(p); flush = fl; err_clr = clr;
    n       = bq.size();
    pe      = (p < WO) ? p : WO;
    pe      = (pe < n) ? pe : n;
    do_push = dv && ((BW - n) >= WI);
    viol    = (p > n) || (p > WO);
    if (r) begin
      bq.delete();
      m_err = 1'b0;
    end else begin
      if (fl) bq.delete();
      else repeat (pe) void'(bq.pop_front());
      if (do_push) for (int i = 0; i < WI; i++) bq.push_back(dd[i]);
      if (viol)     m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    e = model_view();
    @(posedge clk);
    #1 exp_q.push_back(e);
  endtask

  // Monitor: compare each registered state against its queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("q",       q,       e.q);
      chk("q_count", q_count, e.qc);
      chk("size",    size,    e.sz);
      chk("d_ready", d_ready, e.rdy);
      chk("err",     err,     e.err);
    end
  end

  initial begin
    // reset state, then a single push
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    // fill to capacity, then drain in nibbles
    step(0, 1, 8'h3C, 0, 0, 0);
    step(0, 1, 8'hFF, 4, 0, 0);   // full: push refused, pop 4
    step(0, 0, 8'h00, 4, 0, 0);
    // simultaneous pop and push at size 8
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    step(0, 1, 8'h3C, 4, 0, 0);
    // underflow pop: size 12 -> pop 7 -> size 5 -> pop 7 clamps to 0
    step(0, 0, 8'h00, 7, 0, 0);
    step(0, 0, 8'h00, 7, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    // pop above WIDTH_OUT, and a clear that coincides with a violation
    step(0, 1, 8'h5A, 0, 0, 0);
    step(0, 0, 8'h00, 12, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1);
    // flush with push, then flush alone
    step(0, 1, 8'hC3, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h77, 3, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    // reset beats push and pop at size 12
    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 1, 8'h22, 4, 0, 0);
    step(0, 0, 8'h00, 15, 0, 0);
    step(0, 1, 8'h33, 0, 0, 0);
    step(1, 1, 8'h44, 4, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int p;
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom), p, ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 7) == 0));
    end
    step(0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
